// File: rtl/melody_seq_if.sv
// Control and note-output bundle between a playback controller and melody_seq.
// Latency: none; this is wiring only.
// Backpressure: none; the sequencer free-runs, and the tone generator follows note_code and tone_en.
interface melody_seq_if;
  logic       start;      // one-cycle request to begin playback from entry 0
  logic       stop;       // one-cycle request to abort playback
  logic       loop;       // level, sampled at the end-of-score decision
  logic [2:0] note_code;  // 0 = rest, 1..7 = Do..Ti
  logic       tone_en;    // tone generator drives the buzzer
  logic [3:0] note_idx;   // current score entry
  logic       busy;       // high while playing or in a gap
  logic       done;       // one-cycle pulse at the natural end of the score

  // Controller side
  modport master (
    output start, stop, loop,
    input  note_code, tone_en, note_idx, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, stop, loop,
    output note_code, tone_en, note_idx, busy, done
  );
endinterface

// File: rtl/melody_seq.sv
// Score sequencer: walks a fixed 16-entry ROM and presents note/tone_en per entry, with silent gaps.
// Latency: start/stop take effect 1 cycle later; all outputs are decoded from registered state only.
// Backpressure: none; the tone generator downstream always follows, and start while busy or in DONE is ignored.
module melody_seq #(
  parameter logic [24:0] BEAT_CNT_MAX = 25'd24_999_999,  // clocks per beat minus 1
  parameter logic [24:0] GAP_CNT_MAX  = 25'd2_499_999    // clocks per inter-note gap minus 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  melody_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One score entry. beats == 0 marks the end of the score.
  typedef struct packed {
    logic [2:0] note;
    logic [1:0] beats;
  } score_ent_t;

  // Fixed score, "Twinkle Twinkle Little Star" first phrase
  function automatic score_ent_t rom_rd(input logic [3:0] idx);
    score_ent_t ent;
    case (idx)
      4'd0:    ent = {3'd1, 2'd1};
      4'd1:    ent = {3'd1, 2'd1};
      4'd2:    ent = {3'd5, 2'd1};
      4'd3:    ent = {3'd5, 2'd1};
      4'd4:    ent = {3'd6, 2'd1};
      4'd5:    ent = {3'd6, 2'd1};
      4'd6:    ent = {3'd5, 2'd2};
      4'd7:    ent = {3'd4, 2'd1};
      4'd8:    ent = {3'd4, 2'd1};
      4'd9:    ent = {3'd3, 2'd1};
      4'd10:   ent = {3'd3, 2'd1};
      4'd11:   ent = {3'd2, 2'd1};
      4'd12:   ent = {3'd2, 2'd1};
      4'd13:   ent = {3'd1, 2'd2};
      default: ent = {3'd0, 2'd0};
    endcase
    return ent;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [24:0] cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;

  score_ent_t  cur_ent;
  score_ent_t  nxt_ent;
  score_ent_t  first_ent;
  logic [3:0]  idx_inc;
  logic [1:0]  last_beat;
  logic        beat_end;
  logic        gap_end;

  // The entry after the current one wraps at 16, so a ROM without an end marker would loop forever.
  assign idx_inc   = idx_q + 4'd1;
  assign cur_ent   = rom_rd(idx_q);
  assign nxt_ent   = rom_rd(idx_inc);
  assign first_ent = rom_rd(4'd0);
  assign last_beat = cur_ent.beats - 2'd1;
  assign beat_end  = (cnt_q == BEAT_CNT_MAX);
  assign gap_end   = (cnt_q == GAP_CNT_MAX);

  // State register with the clock counter, beat counter and score index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 25'd0;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic; stop overrides everything, including a simultaneous start
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;

    if (bus.stop) begin
      state_d = ST_IDLE;
      idx_d   = 4'd0;
      cnt_d   = 25'd0;
      bcnt_d  = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_d  = 4'd0;
            cnt_d  = 25'd0;
            bcnt_d = 2'd0;
            // An empty score finishes immediately rather than playing a zero-length note.
            state_d = (first_ent.beats == 2'd0) ? ST_DONE : ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (beat_end) begin
            cnt_d = 25'd0;
            if (bcnt_q == last_beat) begin
              state_d = ST_GAP;
              bcnt_d  = 2'd0;
            end else begin
              bcnt_d = bcnt_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 25'd1;
          end
        end

        ST_GAP: begin
          if (gap_end) begin
            cnt_d = 25'd0;
            if (nxt_ent.beats != 2'd0) begin
              state_d = ST_PLAY;
              idx_d   = idx_inc;
            end else if (bus.loop) begin
              state_d = ST_PLAY;
              idx_d   = 4'd0;
            end else begin
              // note_idx is held through DONE and cleared on the way back to IDLE.
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 25'd1;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          cnt_d   = 25'd0;
          bcnt_d  = 2'd0;
        end

        default: begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          cnt_d   = 25'd0;
          bcnt_d  = 2'd0;
        end
      endcase
    end
  end

  logic [2:0] note_code_c;
  logic       tone_en_c;
  logic       busy_c;
  logic       done_c;

  // Output decode from registered state only; a rest entry plays silence for its full length
  always_comb begin
    note_code_c = 3'd0;
    tone_en_c   = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      ST_PLAY: begin
        busy_c      = 1'b1;
        note_code_c = cur_ent.note;
        tone_en_c   = (cur_ent.note != 3'd0);
      end
      ST_GAP: begin
        busy_c      = 1'b1;
        note_code_c = cur_ent.note;
      end
      ST_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        note_code_c = 3'd0;
      end
    endcase
  end

  assign bus.note_code = note_code_c;
  assign bus.tone_en   = tone_en_c;
  assign bus.note_idx  = idx_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
Score sequencer that sits directly upstream of the PWM tone generator. It walks a fixed internal score ROM and, for each entry, presents a note code and a tone enable for a programmable number of beats. Between notes it inserts a short silent articulation gap. It supports start/stop control, loop mode, and an end-of-score done pulse.

Parameters:
BEAT_CNT_MAX, 25'd24_999_999, clocks per beat minus 1 (500 ms at 50 MHz)
GAP_CNT_MAX, 25'd2_499_999, clocks per inter-note gap minus 1 (50 ms at 50 MHz)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin playback from entry 0
stop  input  1  one-cycle request to abort playback
loop  input  1  level; when 1, score restarts at entry 0 instead of finishing
note_code  output  3  0 = rest, 1..7 = Do..Ti; feeds the tone generator's note select
tone_en  output  1  1 = tone generator drives the buzzer
note_idx  output  4  current score entry index
busy  output  1  high in PLAY and GAP
done  output  1  one-cycle pulse at natural end of score (non-loop)

Behaviour:
- Reset (async, sys_rst_n low): state=IDLE, note_idx=0, counters=0, note_code=0, tone_en=0, busy=0, done=0.
- Score ROM: 16 entries of {note[2:0], beats[1:0]}. beats=0 is the end marker.
  - Contents, by index: 0:1/1, 1:1/1, 2:5/1, 3:5/1, 4:6/1, 5:6/1, 6:5/2, 7:4/1, 8:4/1, 9:3/1, 10:3/1, 11:2/1, 12:2/1, 13:1/2, 14:end, 15:end.
- Registers: 25-bit clock counter cnt, 2-bit beat counter bcnt, state, note_idx. All outputs are decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, PLAY, GAP, DONE.
- IDLE:
  - start=1 -> PLAY, with note_idx=0, cnt=0, bcnt=0.
  - If entry 0 were the end marker, go to DONE instead (not the case with the shipped ROM).
- PLAY:
  - cnt counts 0..BEAT_CNT_MAX. When cnt wraps, bcnt increments.
  - When cnt==BEAT_CNT_MAX and bcnt==beats-1 -> GAP, with cnt=0, bcnt=0.
  - PLAY therefore lasts exactly beats*(BEAT_CNT_MAX+1) cycles.
- GAP:
  - Lasts GAP_CNT_MAX+1 cycles.
  - On the final cycle, the entry at note_idx+1 (4-bit wrap) is examined:
    - not an end marker -> PLAY, note_idx+1;
    - end marker and loop=1 -> PLAY, note_idx=0, no done pulse;
    - end marker and loop=0 -> DONE.
  - loop is sampled only at this decision point.
- DONE: lasts 1 cycle with done=1, then -> IDLE with note_idx=0.
- Output decode:
  - note_code = ROM note at note_idx in PLAY and GAP, 0 otherwise.
  - tone_en = (state==PLAY) && (note_code!=0). A rest entry keeps tone_en low for its full duration.
  - busy = PLAY or GAP.
- Control boundary cases:
  - stop=1 in any state -> IDLE next cycle. note_idx=0, counters cleared, tone_en=0, no done pulse.
  - stop and start in the same cycle: stop wins.
  - start while busy or in DONE is ignored; there is no restart mid-score.
- Reset asserted mid-playback forces the reset values immediately, independent of the clock.
- Counter widths: cnt is 25 bits and compares against the parameters exactly, with no overflow. bcnt is 2 bits, which covers the maximum of 3 beats.

Test Plan:
Parameters for all scenarios: BEAT_CNT_MAX=9, GAP_CNT_MAX=1.
1. Reset, then a 1-cycle start -> next cycle: busy=1, note_idx=0, note_code=1, tone_en=1 for exactly 10 cycles; then tone_en=0 for 2 cycles with note_code=1; then note_idx=1.
2. Let the full score run with loop=0:
   - tone_en high-times in order: 10,10,10,10,10,10,20,10,10,10,10,10,10,20 cycles; each followed by a 2-cycle low gap.
   - busy high for exactly 188 cycles.
   - done pulses once, for 1 cycle, on the cycle after busy falls.
   - Then IDLE with note_code=0.
3. loop=1 held through the end -> after entry 13's gap, note_idx returns to 0 with tone_en rising; done never asserts; busy stays high.
4. stop pulsed while note_idx=6 in mid-PLAY -> next cycle: tone_en=0, busy=0, note_idx=0, done=0. A following start restarts from entry 0.
5. start and stop in the same cycle from IDLE -> remains IDLE, busy=0. A start pulse at note_idx=3 while busy -> ignored; playback timing unchanged.
6. sys_rst_n pulled low asynchronously during GAP (between clock edges) -> all outputs 0 immediately. After release, stays IDLE until start.
